// File: rtl/ram_master.sv
// ram_master: load/store front-end for the 4 x 8-bit byte-lane data RAM.
// Takes one request at a time. Stores produce a one-cycle write strobe with
// per-lane enables and replicated data. Loads issue a read, wait one cycle
// for the RAM, then extract and extend the selected lanes. Every accepted
// request gets exactly one response.
// Optional build macro: RAM_MASTER_RANGE_CHK_EN. When defined, addresses
// outside [BASE_ADDR, BASE_ADDR + 2**RAM_ADDR_WIDTH) fault. When undefined,
// no range check is made and such addresses alias into the RAM window.
module ram_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 14,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [3:0]            ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [31:0]           ram_wr_data_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [31:0]           ram_rd_data_i
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DATA, RESP} state_t;

  state_t state, state_nx;

  logic            acc;
  logic            err;
  logic            align_err;
  logic            range_err;
  logic            out_of_range;
  logic [ADDR_WIDTH-1:0] off;
  logic [3:0]      mask;
  logic [31:0]     wdata_rep;
  logic [1:0]      size_q;
  logic [1:0]      lo_q;
  logic            uns_q;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_ext;

  assign req_ready_o = (state == IDLE);
  assign acc         = req_valid_i & req_ready_o;

  // Offset into the window; a borrow (addr < base) also lands in the upper bits.
  assign off          = req_addr_i - BASE_ADDR;
  assign out_of_range = (req_addr_i < BASE_ADDR) || (|(off >> RAM_ADDR_WIDTH));

`ifdef RAM_MASTER_RANGE_CHK_EN
  assign range_err = out_of_range;
`else
  // Range test is kept for visibility only; the RAM ignores upper bits.
  logic unused_range;
  assign unused_range = out_of_range;
  assign range_err    = 1'b0;
`endif

  // Decode alignment faults, lane mask and replicated store data.
  always_comb begin
    align_err = 1'b0;
    mask      = 4'b0000;
    wdata_rep = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        mask      = 4'b0001 << req_addr_i[1:0];
        wdata_rep = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        align_err = req_addr_i[0];
        mask      = req_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata_i[15:0]}};
      end
      2'b10: begin
        align_err = |req_addr_i[1:0];
        mask      = 4'b1111;
      end
      default: align_err = 1'b1;
    endcase
  end

  assign err = align_err | range_err;

  // Select the addressed lanes of the returned word and extend them.
  always_comb begin
    ld_byte = ram_rd_data_i[7:0];
    case (lo_q)
      2'd1:    ld_byte = ram_rd_data_i[15:8];
      2'd2:    ld_byte = ram_rd_data_i[23:16];
      2'd3:    ld_byte = ram_rd_data_i[31:24];
      default: ld_byte = ram_rd_data_i[7:0];
    endcase
    ld_half = lo_q[1] ? ram_rd_data_i[31:16] : ram_rd_data_i[15:0];
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = ram_rd_data_i;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc) state_nx = err ? RESP : (req_we_i ? WRITE : READ);
      WRITE:   state_nx = RESP;
      READ:    state_nx = DATA;
      DATA:    state_nx = RESP;
      RESP:    if (rsp_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered RAM strobes and response; the write enable is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr_en_o   <= '0;
      ram_wr_addr_o <= '0;
      ram_wr_data_o <= '0;
      ram_rd_addr_o <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      size_q        <= '0;
      lo_q          <= '0;
      uns_q         <= 1'b0;
    end else begin
      ram_wr_en_o <= '0;
      case (state)
        IDLE: if (acc) begin
          size_q <= req_size_i;
          lo_q   <= req_addr_i[1:0];
          uns_q  <= req_unsigned_i;
          if (err) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= '0;
          end else if (req_we_i) begin
            ram_wr_en_o   <= mask;
            ram_wr_addr_o <= req_addr_i;
            ram_wr_data_o <= wdata_rep;
          end else begin
            ram_rd_addr_o <= req_addr_i;
          end
        end
        WRITE: begin
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= '0;
        end
        DATA: begin
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= ld_ext;
        end
        RESP: if (rsp_ready_i) rsp_valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ram_master.md
Name: ram_master

Overview:
- Load/store front-end that drives the byte-lane data RAM peripheral (4 x 8-bit simple dual-port banks, synchronous 1-cycle read) on behalf of the core.
- Accepts one load/store request over a valid/ready handshake.
- For stores: generates per-bank byte write enables and lane-replicated write data.
- For loads: issues the read, waits for the RAM latency, then extracts and sign/zero-extends the result.
- Returns exactly one response per request over a valid/ready handshake; one outstanding request at a time.

Parameters:
- ADDR_WIDTH, 32, request address width.
- RAM_ADDR_WIDTH, 14, byte-address width of the RAM window (16 KiB).
- BASE_ADDR, 32'h1000_0000, byte base address of the RAM window.

Ports:
- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous active-low reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request accepted when high with req_valid_i.
- req_we_i  input  1  1 = store, 0 = load.
- req_addr_i  input  ADDR_WIDTH  byte address.
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  input  1  zero-extend loads when 1.
- req_wdata_i  input  32  store data, right-aligned.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumed.
- rsp_rdata_o  output  32  extended load data; 0 for stores and errors.
- rsp_err_o  output  1  access fault.
- ram_wr_en_o  output  4  per-bank write enable, bit i = byte lane i.
- ram_wr_addr_o  output  ADDR_WIDTH  write byte address.
- ram_wr_data_o  output  32  lane-replicated write data.
- ram_rd_addr_o  output  ADDR_WIDTH  read byte address.
- ram_rd_data_i  input  32  RAM read data, valid one cycle after the address is sampled.

Behaviour:
- Clock and reset: clk only; rst_n asynchronous, active-low.
- Reset values: state IDLE; ram_wr_en_o = 0; ram_wr_addr_o, ram_wr_data_o, ram_rd_addr_o = 0; rsp_valid_o = 0; rsp_rdata_o = 0; rsp_err_o = 0. req_ready_o = 1 as soon as rst_n is high.
- All RAM-side and response outputs are registered.
- req_ready_o = (state == IDLE). A request is accepted in cycle T when req_valid_i & req_ready_o.
- Error conditions, checked at accept:
  - req_size_i == 11.
  - Half access with addr[0] != 0.
  - Word access with addr[1:0] != 0.
  - Range violation (see Optional Feature).
- State machine:
  - IDLE -> RESP on error. No RAM strobe is issued; rsp_err_o = 1 at T+1.
  - IDLE -> WRITE on store. In T+1, ram_wr_en_o = mask and ram_wr_addr_o / ram_wr_data_o are valid for exactly one cycle. WRITE -> RESP; rsp_valid_o is high at T+2.
  - IDLE -> READ on load. ram_rd_addr_o is valid in T+1 and held until the next load. READ -> DATA. In T+2, ram_rd_data_i is sampled, the lane is extracted and extended, and the result is registered. DATA -> RESP; rsp_valid_o is high at T+3.
  - RESP: rsp_valid_o, rsp_rdata_o and rsp_err_o are held stable until rsp_ready_i. On the handshake, go to IDLE and clear rsp_valid_o. No new request is accepted in the handshake cycle.
- Byte mask:
  - Byte: 1 << addr[1:0].
  - Half: addr[1] ? 1100 : 0011.
  - Word: 1111.
- Write data:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata unchanged.
- Load extract:
  - Byte: lane addr[1:0].
  - Half: lanes selected by addr[1].
  - Sign-extend unless req_unsigned_i; req_unsigned_i is ignored for word loads.
- Addresses passed to the RAM are the full request addresses. The RAM indexes with bits [RAM_ADDR_WIDTH-1:2].
- Back-to-back: the next request can be accepted no earlier than the cycle after the response handshake.
- Mid-operation reset: ram_wr_en_o drops immediately and the pending request is discarded with no response.

Optional Feature:
- Macro: RAM_MASTER_RANGE_CHK_EN.
- Defined: an address with (addr - BASE_ADDR) >= 2**RAM_ADDR_WIDTH, or addr < BASE_ADDR, is an error. The response has rsp_err_o = 1, there is no RAM access, and rsp_rdata_o = 0.
- Undefined: no range check. Upper address bits are ignored by the RAM, so accesses alias into the window.

Test Plan:
1. Store word 0xDEADBEEF @0x1000_0010 -> T+1: ram_wr_en_o = 1111, ram_wr_data_o = 0xDEADBEEF; T+2: rsp_valid_o = 1, rsp_err_o = 0.
2. Store byte 0x5A @0x1000_0013 -> ram_wr_en_o = 1000, ram_wr_data_o = 0x5A5A5A5A. Then load byte signed @0x1000_0012 with RAM word 0x80BE_0000 -> rsp_rdata_o = 0xFFFFFFBE at T+3.
3. Load half unsigned @0x1000_0012 with RAM word 0x80BE_1234 -> rsp_rdata_o = 0x000080BE. The same load signed -> 0xFFFF80BE.
4. Misaligned loads and stores -> rsp_err_o = 1 at T+1 with ram_wr_en_o never nonzero:
   - Load word @0x1000_0002.
   - Store half @0x1000_0001.
   - size = 11.
5. Hold rsp_ready_i = 0 for 5 cycles after a load -> rsp_valid_o and rsp_rdata_o stable, req_ready_o = 0. Release -> IDLE the next cycle, then a new request is accepted.
6. With RAM_MASTER_RANGE_CHK_EN defined, store @0x1000_4000 -> rsp_err_o = 1, no write. Without the macro -> ram_wr_en_o = 1111 (aliases to offset 0). Also assert rst_n in the WRITE state -> ram_wr_en_o = 0 immediately, no response.
